// File: rtl/sobel_edge_filter.sv
// rtl/sobel_edge_filter.sv - streaming 3x3 Sobel edge detector on RGB565 pixels
//
// Ports:
//   iCLK    in   1   pixel clock; every register in the block runs on it
//   iRST_N  in   1   asynchronous active-low reset
//   iFVAL   in   1   frame valid; while low the column/row counters are held at 0
//   iDVAL   in   1   input pixel strobe, one pixel per high cycle
//   iDATA   in  16   RGB565 input pixel {R5,G6,B5}
//   oDVAL   out  1   output pixel strobe, iDVAL delayed by exactly 3 cycles
//   oDATA   out 16   RGB565 edge pixel, valid with oDVAL
//
// Build option: SOBEL_GRAD_OUT_EN selects a grey gradient-magnitude output
// instead of the binary threshold output.

`timescale 1ns/1ps

module sobel_edge_filter #(
  parameter int LINE_W = 640,
  parameter int THRESH = 64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [15:0] iDATA,
  output logic        oDVAL,
  output logic [15:0] oDATA
);

  localparam int CW = (LINE_W > 4) ? $clog2(LINE_W) : 2;

  logic [CW-1:0] col;
  logic [1:0]    row;
  logic [CW-1:0] eff_col;
  logic [1:0]    eff_row;

  logic [10:0] y_sum;
  logic [7:0]  y;

  logic [7:0] lb1 [LINE_W];
  logic [7:0] lb2 [LINE_W];
  logic [7:0] l1_rd;
  logic [7:0] l2_rd;

  logic [7:0] y_q;
  logic       dval1;
  logic       border1;

  logic [7:0] win [3][3];
  logic       dval2;
  logic       border2;

  logic [11:0] gx_p, gx_n, gy_p, gy_n;
  logic [11:0] gx, gy;
  logic [10:0] ax, ay, mag;
  logic [7:0]  mag_sat;
  logic [15:0] edge_pix;

  // A pixel arriving while the frame is inactive is handled as row 0 / col 0,
  // even in the cycle where the counters have not yet been cleared.
  assign eff_col = iFVAL ? col : '0;
  assign eff_row = iFVAL ? row : 2'd0;

  // Y = (2*R8 + 5*G8 + B8) >> 3 with all terms zero-extended to 11 bits.
  always_comb begin
    y_sum = {2'b00, iDATA[15:11], 4'b0000}
          + {1'b0, iDATA[10:5], 4'b0000}
          + {3'b000, iDATA[10:5], 2'b00}
          + {3'b000, iDATA[4:0], 3'b000};
    y = y_sum[10:3];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      col <= '0;
      row <= 2'd0;
    end else if (!iFVAL) begin
      col <= '0;
      row <= 2'd0;
    end else if (iDVAL) begin
      if (col == CW'(LINE_W - 1)) begin
        col <= '0;
        if (row != 2'd2) row <= row + 2'd1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Cascaded line buffers: read-before-write at the same address, so L1
  // returns the previous line and its old value moves down into L2.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      l1_rd        <= lb1[eff_col];
      l2_rd        <= lb2[eff_col];
      lb1[eff_col] <= y;
      lb2[eff_col] <= lb1[eff_col];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      y_q     <= 8'd0;
      dval1   <= 1'b0;
      border1 <= 1'b0;
    end else begin
      dval1 <= iDVAL;
      if (iDVAL) begin
        y_q     <= y;
        border1 <= (eff_row != 2'd2) || (eff_col < CW'(2));
      end
    end
  end

  // Row 0 of the window is the oldest line, column 0 the oldest column.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= 8'd0;
        end
      end
      dval2   <= 1'b0;
      border2 <= 1'b0;
    end else begin
      dval2 <= dval1;
      if (dval1) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= l2_rd;
        win[1][2] <= l1_rd;
        win[2][2] <= y_q;
        border2   <= border1;
      end
    end
  end

  always_comb begin
    gx_p = {4'b0, win[0][2]} + {3'b0, win[1][2], 1'b0} + {4'b0, win[2][2]};
    gx_n = {4'b0, win[0][0]} + {3'b0, win[1][0], 1'b0} + {4'b0, win[2][0]};
    gy_p = {4'b0, win[2][0]} + {3'b0, win[2][1], 1'b0} + {4'b0, win[2][2]};
    gy_n = {4'b0, win[0][0]} + {3'b0, win[0][1], 1'b0} + {4'b0, win[0][2]};
    gx   = gx_p - gx_n;
    gy   = gy_p - gy_n;
    // Each gradient is bounded by +/-1020, so 11 bits of magnitude suffice.
    ax   = gx[11] ? (~gx[10:0] + 11'd1) : gx[10:0];
    ay   = gy[11] ? (~gy[10:0] + 11'd1) : gy[10:0];
    mag  = ax + ay;
    mag_sat = (mag > 11'd255) ? 8'hFF : mag[7:0];
`ifdef SOBEL_GRAD_OUT_EN
    edge_pix = {mag_sat[7:3], mag_sat[7:2], mag_sat[7:3]};
`else
    edge_pix = ({4'b0000, mag_sat} >= 12'(THRESH)) ? 16'hFFFF : 16'h0000;
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDVAL <= 1'b0;
      oDATA <= 16'h0000;
    end else begin
      oDVAL <= dval2;
      oDATA <= (dval2 && !border2) ? edge_pix : 16'h0000;
    end
  end

endmodule

// File: doc/sobel_edge_filter.md
# sobel_edge_filter

Streaming 3x3 Sobel edge detector for the camera pixel path. It takes one RGB565 pixel per valid strobe from the colour-conversion/truncation stage and forms 8-bit luma. It keeps two line buffers and emits one RGB565 edge pixel per input pixel, which feeds the filter-select register ahead of the SRAM write port. It runs entirely in the camera pixel-clock domain.

## Interface
Parameters:
- LINE_W, 640: active pixels per line; the line-buffer depth and column wrap point.
- THRESH, 64: edge threshold on the 8-bit saturated gradient magnitude.

Ports:
- iCLK  in  1  pixel clock. Single clock: every register in the block is clocked by it.
- iRST_N  in  1  asynchronous, active-low reset. Reset is asserted asynchronously.
- iFVAL  in  1  frame valid. While low, the column/row counters are synchronously held at 0.
- iDVAL  in  1  input pixel strobe, one pixel per high cycle.
- iDATA  in  16  RGB565 pixel {R5,G6,B5}, sampled when iDVAL=1.
- oDVAL  out  1  output pixel strobe. It is iDVAL delayed by exactly 3 cycles.
- oDATA  out  16  RGB565 edge pixel, valid when oDVAL=1.

## Operation
- Luma: R8={R5,3'b0}, G8={G6,2'b0}, B8={B5,3'b0}; Y=(2*R8+5*G8+B8)>>3, computed with an 11-bit intermediate. Result range is 0..250 (white gives 250).
- Counters:
  - col (0..LINE_W-1) increments on each iDVAL and wraps LINE_W-1 -> 0.
  - On that wrap, row increments, saturating at 2.
  - Both counters clear while iFVAL=0.
  - Excess pixels in a line simply wrap to the next line; there is no error flag.
- Line buffers: two LINE_W x 8 synchronous RAMs in a cascade.
  - At address col, read the old values: L1 = previous line, L2 = two lines back.
  - Write Y into L1 and the old L1 value into L2.
  - For a given address, the read returns pre-write data.
- Window: a 3x3 shift register of {L2, L1, Y} columns; it shifts only on delayed-valid cycles.
  - Entries p[r][c] with r=0 oldest line, c=0 oldest column. The centre is p11.
- Gradient:
  - Gx=(p02+2p12+p22)-(p00+2p10+p20), 12-bit signed.
  - Gy=(p20+2p21+p22)-(p00+2p01+p02), 12-bit signed.
  - mag=|Gx|+|Gy| (11-bit), saturated to 255.
- Output: white 16'hFFFF when mag>=THRESH, else 16'h0000.
- Output position: the pixel emitted for input (row r, col c) is the window centred on (r-1, c-1).
- Border: when the input pixel has row<2 or col<2 (counter values at acceptance), oDATA=16'h0000 regardless of mag. This suppresses wrap-around mixing across lines.
- Output count always equals input count. Gaps in iDVAL are preserved on oDVAL.

## Timing
- Pipeline stages:
  - Cycle n: iDVAL=1.
  - n+1: Y registered; line-buffer data returned.
  - n+2: window shifted.
  - n+3: oDATA/oDVAL registered.
- Latency is 3 cycles, with no stalls and no backpressure. Full throughput is 1 pixel/cycle.
- Reset values: oDVAL=0, oDATA=16'h0000, col=0, row=0, window=0, delayed-valid pipeline=0. Line-buffer contents are undefined, but are masked by the border rule.
- Reset mid-line: in-flight pixels are discarded (no oDVAL for them). The next accepted pixel is treated as row 0, col 0.
- iFVAL falling mid-line: counters clear on the next edge; pixels already in the pipe still emit normally.
- iDVAL=1 coincident with iFVAL=0: the pixel is processed as col 0/row 0 (border output) and the counters stay 0.

## Configuration
- Macro SOBEL_GRAD_OUT_EN:
  - Defined: oDATA outputs the gradient as grey, {mag[7:3], mag[7:2], mag[7:3]}. THRESH is unused; the border rule still applies.
  - Undefined: binary threshold output as above.

## Test plan
- Use LINE_W=8 and THRESH=64 throughout.
- Uniform 16'hFFFF for 4 lines (32 pixels) -> 32 oDVAL pulses, each exactly 3 cycles after its iDVAL; all oDATA=16'h0000.
- Per line, cols 0-3=16'h0000 and cols 4-7=16'hFFFF, 4 lines -> input rows 2-3 give oDATA=16'hFFFF at input cols 4 and 5 only (Gx=1000, saturated); every other pixel is 16'h0000.
- Same step with 16'h4000 on the right (Y=16, Gx=64=THRESH) -> white at rows 2-3, cols 4-5.
- Same step with 16'h3800 on the right (Y=14, Gx=56) -> all black.
- SOBEL_GRAD_OUT_EN defined:
  - 16'h4000 step -> 16'h4208 at those positions.
  - 16'hFFFF step -> 16'hFFFF.
- Reset and frame restart:
  - Drop iRST_N after 13 input pixels -> oDVAL=0 and oDATA=0 immediately. After release, re-run the edge test; the result must be identical.
  - Drop iFVAL for 1 cycle mid-line 2 -> the following 16 pixels all output 16'h0000 (border rows).
